// File: rtl/hc153_scan_reader.sv
// Scans a dual 4:1 HC153-style mux over two wires and rebuilds both 4-bit inputs into q1/q2.
// Latency: done pulses 4*(SETTLE_CYCLES+1) cycles after the start-accept edge; results are registered.
// Backpressure: none; start is honoured only in IDLE and is dropped during a scan. Option: MUX_SCAN_VERIFY_EN.
module hc153_scan_reader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       sel_b,
    output logic       sel_a,
    output logic       ng1,
    output logic       ng2,
    input  logic       y1,
    input  logic       y2,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES);

    // The settle counter is 4 bits wide; the verify build needs a cnt==1 slot.
    generate
        if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 0..15");
        end
`ifdef MUX_SCAN_VERIFY_EN
        if (SETTLE_CYCLES == 0) begin : g_bad_verify
            $error("SETTLE_CYCLES must be at least 1 when verification is enabled");
        end
`endif
    endgenerate

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] sel, sel_n;
    logic [3:0] sh1, sh1_n, sh2, sh2_n;
    logic [3:0] q1_n, q2_n;
    logic       busy_n, done_n, valid_n, ng_n;

`ifdef MUX_SCAN_VERIFY_EN
    logic v1, v1_n, v2, v2_n;
    logic flag, flag_n;
    logic err_r, err_n;
    logic mismatch;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign sel_b = sel[1];
    assign sel_a = sel[0];

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        sh1_n   = sh1;
        sh2_n   = sh2;
        q1_n    = q1;
        q2_n    = q2;
        busy_n  = busy;
        done_n  = 1'b0;
        valid_n = valid;
        ng_n    = ng1;
`ifdef MUX_SCAN_VERIFY_EN
        v1_n     = v1;
        v2_n     = v2;
        flag_n   = flag;
        err_n    = err_r;
        mismatch = (y1 != v1) || (y2 != v2);
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    busy_n  = 1'b1;
                    ng_n    = 1'b0;
                    sel_n   = 2'd0;
                    cnt_n   = RELOAD;
                    sh1_n   = 4'd0;
                    sh2_n   = 4'd0;
`ifdef MUX_SCAN_VERIFY_EN
                    flag_n  = 1'b0;
`endif
                end
            end
            SCAN: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
`ifdef MUX_SCAN_VERIFY_EN
                    // Early sample, compared against the final sample one cycle later.
                    if (cnt == 4'd1) begin
                        v1_n = y1;
                        v2_n = y2;
                    end
`endif
                end else begin
                    // Select 00 carries C[3], so the bit index is the inverted select.
                    sh1_n[~sel] = y1;
                    sh2_n[~sel] = y2;
`ifdef MUX_SCAN_VERIFY_EN
                    flag_n = flag | mismatch;
`endif
                    if (sel != 2'd3) begin
                        sel_n = sel + 2'd1;
                        cnt_n = RELOAD;
                    end else begin
                        q1_n    = sh1_n;
                        q2_n    = sh2_n;
                        done_n  = 1'b1;
                        valid_n = 1'b1;
                        busy_n  = 1'b0;
                        ng_n    = 1'b1;
                        sel_n   = 2'd0;
                        state_n = IDLE;
`ifdef MUX_SCAN_VERIFY_EN
                        err_n   = flag | mismatch;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            sel   <= 2'd0;
            sh1   <= 4'd0;
            sh2   <= 4'd0;
            q1    <= 4'd0;
            q2    <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            ng1   <= 1'b1;
            ng2   <= 1'b1;
`ifdef MUX_SCAN_VERIFY_EN
            v1    <= 1'b0;
            v2    <= 1'b0;
            flag  <= 1'b0;
            err_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            sh1   <= sh1_n;
            sh2   <= sh2_n;
            q1    <= q1_n;
            q2    <= q2_n;
            busy  <= busy_n;
            done  <= done_n;
            valid <= valid_n;
            ng1   <= ng_n;
            ng2   <= ng_n;
`ifdef MUX_SCAN_VERIFY_EN
            v1    <= v1_n;
            v2    <= v2_n;
            flag  <= flag_n;
            err_r <= err_n;
`endif
        end
    end

endmodule
